// File: rtl/smoldvi_stream_gearbox.sv
// smoldvi_stream_gearbox
//
// Single-clock width converter between a W_IN-bit and a W_OUT-bit valid/ready
// stream. Handles any ratio, including non-integer ones. Incoming words are
// appended above the buffered bits. Outgoing words are taken from the bottom,
// so buf_q[0] is always the oldest bit.
//
// Two extra controls:
//   slip  - drop the oldest buffered bit, used for serialiser lane alignment
//   flush - zero-pad a partial tail up to one full output word
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_data/valid/ready    input stream; in_ready means a full word fits
//   out_data/valid/ready   output stream; out_data is the oldest W_OUT bits
//   flush                  pad a partial tail (1..W_OUT-1 bits) to W_OUT bits
//   slip                   discard the oldest bit; ignored on pop or when empty
//   level                  number of valid buffered bits
module smoldvi_stream_gearbox #(
   parameter int unsigned W_IN      = 10,
   parameter int unsigned W_OUT     = 4,
   parameter int unsigned W_BUF     = W_IN + W_OUT,
   parameter int unsigned MSB_FIRST = 0,
   parameter int unsigned W_LEVEL   = $clog2(W_BUF + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [W_IN-1:0]    in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [W_OUT-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   input  logic               flush,
   input  logic               slip,
   output logic [W_LEVEL-1:0] level
);

   if (W_IN < 1 || W_OUT < 1) begin : g_bad_width
      $error("smoldvi_stream_gearbox: W_IN and W_OUT must be at least 1");
   end
   if (W_BUF < W_IN + W_OUT - 1) begin : g_bad_buf
      $error("smoldvi_stream_gearbox: W_BUF must be >= W_IN + W_OUT - 1");
   end

   localparam logic [W_LEVEL-1:0] LvlOut  = W_LEVEL'(W_OUT);
   localparam logic [W_LEVEL-1:0] LvlIn   = W_LEVEL'(W_IN);
   localparam logic [W_LEVEL-1:0] LvlOne  = W_LEVEL'(1);
   // Highest level at which a whole input word still fits.
   localparam logic [W_LEVEL-1:0] LvlRoom = W_LEVEL'(W_BUF - W_IN);

   logic [W_BUF-1:0]   buf_q, buf_d;
   logic [W_LEVEL-1:0] level_q, level_d;
   logic [W_IN-1:0]    in_word;
   logic [W_OUT-1:0]   out_word;
   logic               pop, push;

   // Normalise to oldest-bit-at-index-0 on entry and undo it on exit.
   for (genvar g = 0; g < W_IN; g++) begin : g_in_order
      assign in_word[g] = (MSB_FIRST != 0) ? in_data[W_IN-1-g] : in_data[g];
   end

   assign out_word = buf_q[W_OUT-1:0];

   for (genvar g = 0; g < W_OUT; g++) begin : g_out_order
      assign out_data[g] = (MSB_FIRST != 0) ? out_word[W_OUT-1-g] : out_word[g];
   end

   // in_ready is based on the registered level only. A same-cycle pop does
   // not create room, which keeps the ready path free of out_ready.
   assign out_valid = (level_q >= LvlOut);
   assign in_ready  = (level_q <= LvlRoom);
   assign level     = level_q;

   assign pop  = out_valid & out_ready;
   assign push = in_valid & in_ready;

   // Ordered update: pop or slip, then push, then flush. Bits above the level
   // are always zero, so a push can be ORed in and a flush pads with zeros
   // simply by raising the level.
   always_comb begin
      buf_d   = buf_q;
      level_d = level_q;

      if (pop) begin
         buf_d   = buf_d >> W_OUT;
         level_d = level_d - LvlOut;
      end else if (slip && (level_d != '0)) begin
         buf_d   = buf_d >> 1;
         level_d = level_d - LvlOne;
      end

      if (push) begin
         buf_d   = buf_d | (W_BUF'(in_word) << level_d);
         level_d = level_d + LvlIn;
      end

      if (flush && (level_d != '0) && (level_d < LvlOut)) begin
         level_d = LvlOut;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q   <= '0;
         level_q <= '0;
      end else begin
         buf_q   <= buf_d;
         level_q <= level_d;
      end
   end

endmodule
